// File: rtl/cpu_control.sv
// Instruction sequencer for the 8-bit accumulator CPU: fetch, execute, memory handshake, branches.
// Latency: ALU/LD/branch 2 cycles, ST 3 cycles, plus one cycle per mem_ready=0 wait cycle.
// Backpressure: EXEC_A (memory read) and EXEC_B (memory write) stall indefinitely until mem_ready.
module cpu_control #(
  parameter int PC_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      instr_in,
  input  logic            c,
  input  logic            z,
  input  logic            mem_ready,
  output logic [PC_W-1:0] pc,
  output logic [7:0]      ir,
  output logic [4:0]      mem_addr,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic            ldAcc,
  output logic            useAlu,
  output logic            dbusSelect,
  output logic [1:0]      phase,
  output logic            halted
);

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    EXEC_A = 2'b01,
    EXEC_B = 2'b10,
    HALT   = 2'b11
  } state_t;

  state_t          state;
  logic [2:0]      opcode;
  logic [PC_W-1:0] target;

  assign opcode   = ir[7:5];
  assign target   = PC_W'(ir[4:0]);
  assign mem_addr = ir[4:0];
  assign phase    = state;

  // mem_rd is only ever high in EXEC_A of opcodes 000-100, so ir[7] alone
  // separates LD from the ALU ops; the strobe fires in the completing cycle.
  assign useAlu = mem_rd & ~ir[7] & mem_ready;
  assign ldAcc  = mem_rd &  ir[7] & mem_ready;

  // Sequencer: state, pc, ir and the registered memory/bus strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FETCH;
      pc         <= '0;
      ir         <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      dbusSelect <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          ir     <= instr_in;
          pc     <= pc + PC_W'(1);
          state  <= EXEC_A;
          // Read request is raised for the upcoming EXEC_A of ADD/SUB/NAND/SHIFT/LD.
          mem_rd <= (instr_in[7:5] <= 3'b100);
        end
        EXEC_A: begin
          case (opcode)
            3'b101: begin
              state      <= EXEC_B;
              mem_wr     <= 1'b1;
              dbusSelect <= 1'b1;
            end
            3'b110: begin
              if (z) pc <= target;
              state <= FETCH;
            end
            3'b111: begin
              if (ir[4:0] == 5'd0) begin
                state  <= HALT;
                halted <= 1'b1;
              end else begin
                if (c) pc <= target;
                state <= FETCH;
              end
            end
            default: begin
              if (mem_ready) begin
                mem_rd <= 1'b0;
                state  <= FETCH;
              end
            end
          endcase
        end
        EXEC_B: begin
          if (mem_ready) begin
            mem_wr     <= 1'b0;
            dbusSelect <= 1'b0;
            state      <= FETCH;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control.sv
// Bench for cpu_control: instruction-level model expands each instruction into per-cycle expectations.
// Latency: checked cycle by cycle against the expanded trace.
// Backpressure: mem_ready wait cycles are chosen by the model and driven from the trace.
module tb_cpu_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] instr_in;
  logic       c = 1'b0;
  logic       z = 1'b0;
  logic       mem_ready = 1'b0;
  logic [4:0] pc;
  logic [7:0] ir;
  logic [4:0] mem_addr;
  logic       mem_rd, mem_wr, ldAcc, useAlu, dbusSelect, halted;
  logic [1:0] phase;

  logic [7:0] prog [32];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Combinational program memory.
  assign instr_in = prog[pc];

  cpu_control #(.PC_W(5)) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .c(c), .z(z),
    .mem_ready(mem_ready), .pc(pc), .ir(ir), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .ldAcc(ldAcc), .useAlu(useAlu),
    .dbusSelect(dbusSelect), .phase(phase), .halted(halted)
  );

  // One expected cycle: inputs to drive, then outputs required during it.
  typedef struct packed {
    logic       rdy;
    logic       fc;
    logic       fz;
    logic [4:0] pc;
    logic [7:0] ir;
    logic [1:0] ph;
    logic       rd;
    logic       wr;
    logic       ld;
    logic       ua;
    logic       ds;
    logic       hl;
  } cyc_t;

  cyc_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cyc_t idle(input logic [4:0] p, input logic [7:0] i, input logic [1:0] ph);
    cyc_t e;
    e     = '0;
    e.rdy = 1'($urandom_range(0, 1));
    e.fc  = 1'($urandom_range(0, 1));
    e.fz  = 1'($urandom_range(0, 1));
    e.pc  = p;
    e.ir  = i;
    e.ph  = ph;
    return e;
  endfunction

  // Instruction-level model: execute n instructions from reset, emitting the cycle trace.
  // wfix<0 picks random wait counts 0..3; ffix<0 leaves branch flags random.
  task automatic gen(input int n, input int wfix, input int ffix);
    logic [4:0] mpc;
    logic [7:0] mir;
    logic [2:0] op;
    logic [4:0] a;
    logic       taken;
    int         w;
    cyc_t       e;
    q.delete();
    mpc = 5'd0;
    mir = 8'd0;
    for (int k = 0; k < n; k++) begin
      q.push_back(idle(mpc, mir, 2'd0));
      mir = prog[mpc];
      mpc = mpc + 5'd1;
      op  = mir[7:5];
      a   = mir[4:0];
      w   = (wfix >= 0) ? wfix : int'($urandom_range(0, 3));
      if (op <= 3'd4) begin
        for (int i = 0; i <= w; i++) begin
          e     = idle(mpc, mir, 2'd1);
          e.rd  = 1'b1;
          e.rdy = (i == w);
          e.ld  = (i == w) && (op == 3'd4);
          e.ua  = (i == w) && (op < 3'd4);
          q.push_back(e);
        end
      end else if (op == 3'd5) begin
        q.push_back(idle(mpc, mir, 2'd1));
        for (int i = 0; i <= w; i++) begin
          e     = idle(mpc, mir, 2'd2);
          e.wr  = 1'b1;
          e.ds  = 1'b1;
          e.rdy = (i == w);
          q.push_back(e);
        end
      end else begin
        e = idle(mpc, mir, 2'd1);
        if (ffix >= 0) begin
          e.fz = 1'(ffix);
          e.fc = 1'(ffix);
        end
        q.push_back(e);
        if (op == 3'd7 && a == 5'd0) begin
          for (int i = 0; i < 3; i++) begin
            e    = idle(mpc, mir, 2'd3);
            e.hl = 1'b1;
            q.push_back(e);
          end
          return;
        end
        taken = (op == 3'd6) ? e.fz : e.fc;
        if (taken) mpc = a;
      end
    end
  endtask

  // Drive and check the trace; entered and left on a falling edge.
  task automatic run_q();
    cyc_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      mem_ready = e.rdy;
      c = e.fc;
      z = e.fz;
      #1;
      chk("cycle{pc,ir,phase,rd,wr,ld,ua,ds,hl}",
          32'({pc, ir, phase, mem_rd, mem_wr, ldAcc, useAlu, dbusSelect, halted}),
          32'({e.pc, e.ir, e.ph, e.rd, e.wr, e.ld, e.ua, e.ds, e.hl}));
      if (e.rd | e.wr) chk("mem_addr", 32'(mem_addr), 32'(e.ir[4:0]));
      chk("strobe_onehot", 32'($countones({ldAcc, useAlu, dbusSelect}) <= 1), 32'(1));
      chk("rd_wr_excl", 32'(mem_rd & mem_wr), 32'(0));
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset_state", 32'({pc, ir, phase, mem_rd, mem_wr, ldAcc, useAlu, dbusSelect, halted}), 32'(0));
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 32; i++) prog[i] = v;
  endtask

  initial begin
    // LD 3; ADD 4; ST 5; HALT with mem_ready effectively high.
    fill(8'hE0);
    prog[0] = 8'h83; prog[1] = 8'h04; prog[2] = 8'hA5; prog[3] = 8'hE0;
    gen(10, 0, -1);
    chk("pin_len", 32'(q.size()), 32'(12));
    chk("pin_ld_c2", 32'(q[1].ld), 32'(1));
    chk("pin_ua_c4", 32'(q[3].ua), 32'(1));
    chk("pin_st_c7", 32'({q[6].wr, q[6].ds, q[6].ir[4:0]}), 32'({1'b1, 1'b1, 5'd5}));
    chk("pin_halt_c10", 32'({q[9].hl, q[9].pc}), 32'({1'b1, 5'd4}));
    do_reset();
    run_q();

    // LD with three wait cycles.
    fill(8'hE0);
    prog[0] = 8'h87;
    gen(5, 3, -1);
    chk("pin_ld_wait", 32'({q[1].rd, q[2].rd, q[3].rd, q[4].rd, q[3].ld, q[4].ld, q[5].rd}),
        32'(7'b1111010));
    do_reset();
    run_q();

    // JZ/JC 0x12 with the flag set and clear.
    for (int t = 0; t < 4; t++) begin
      fill(8'hE0);
      prog[0] = (t < 2) ? 8'hD2 : 8'hF2;
      gen(3, 0, t % 2);
      chk("pin_branch_pc", 32'(q[2].pc), (t % 2 == 1) ? 32'h12 : 32'h1);
      do_reset();
      run_q();
    end

    // Straight-line NAND code wraps pc from 31 to 0.
    fill(8'h41);
    gen(34, 0, -1);
    chk("pin_wrap", 32'({q[63].pc, q[64].pc}), 32'(0));
    chk("pin_pc31", 32'(q[62].pc), 32'(31));
    do_reset();
    run_q();

    // Reset during an EXEC_B wait of ST.
    fill(8'hE0);
    prog[0] = 8'hA5;
    do_reset();
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("st_wait_execb", 32'({mem_wr, dbusSelect, phase}), 32'({1'b1, 1'b1, 2'b10}));
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("reset_mid_st", 32'({mem_wr, dbusSelect, pc, phase}), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("after_release", 32'({pc, phase, mem_wr}), 32'(0));

    // Random 200-instruction run with random waits and flags.
    for (int i = 0; i < 32; i++) begin
      prog[i] = 8'($urandom);
      if (prog[i] == 8'hE0) prog[i] = 8'hE1;
    end
    gen(200, -1, -1);
    do_reset();
    run_q();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
